// File: rtl/alu_result_stage_if.sv
// Producer/consumer bundle for alu_result_stage: result input, flagged-result output, sticky control.
// The stage binds to the slave modport; the driving/consuming environment binds to master.
interface alu_result_stage_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [WIDTH-1:0] in_r1;
  logic [WIDTH-1:0] in_r2;
  logic [WIDTH-1:0] in_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_neg;
  logic             out_carry;
  logic             out_ovf;
  logic [1:0]       count;
  logic             clr_sticky;
  logic             sticky_ovf;

  modport master (
    output in_valid, in_op, in_r1, in_r2, in_result, out_ready, clr_sticky,
    input  in_ready, out_valid, out_result, out_zero, out_neg, out_carry, out_ovf,
           count, sticky_ovf
  );

  modport slave (
    input  in_valid, in_op, in_r1, in_r2, in_result, out_ready, clr_sticky,
    output in_ready, out_valid, out_result, out_zero, out_neg, out_carry, out_ovf,
           count, sticky_ovf
  );
endinterface

// File: rtl/alu_result_stage.sv
// Purpose: 2-entry flagged result FIFO behind the add/sub ALU; sticky overflow under STICKY_OVF_EN.
// Latency: 1 cycle from push to out_valid when empty; 1 result/cycle with out_ready held high.
// Backpressure: in_ready = !full from registered count only; out_* hold while out_valid && !out_ready.
module alu_result_stage #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  alu_result_stage_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;
  } entry_t;

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  logic       full;
  logic       push;
  logic       pop;
  entry_t     new_entry;
  entry_t     head;

  logic [WIDTH-1:0] r2_eff;
  logic [WIDTH:0]   sum;
  logic             same_sign;

  // Subtract is r1 + ~r2 + 1, so its carry-out is the "no borrow" flag directly.
  assign r2_eff    = bus.in_op ? ~bus.in_r2 : bus.in_r2;
  assign sum       = {1'b0, bus.in_r1} + {1'b0, r2_eff} + {{WIDTH{1'b0}}, bus.in_op};
  assign same_sign = (bus.in_r1[MSB] == (bus.in_r2[MSB] ^ bus.in_op));

  always_comb begin
    new_entry        = '0;
    new_entry.result = bus.in_result;
    new_entry.zero   = (bus.in_result == '0);
    new_entry.neg    = bus.in_result[MSB];
    new_entry.carry  = sum[WIDTH];
    new_entry.ovf    = same_sign && (bus.in_result[MSB] != bus.in_r1[MSB]);
  end

  assign full = (count == 2'd2);
  assign push = bus.in_valid && !full;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // in_ready is forced high during reset; the reset branch above discards any push.
  assign bus.in_ready   = rst || !full;
  assign bus.out_valid  = (count != 2'd0);
  assign bus.out_result = head.result;
  assign bus.out_zero   = head.zero;
  assign bus.out_neg    = head.neg;
  assign bus.out_carry  = head.carry;
  assign bus.out_ovf    = head.ovf;
  assign bus.count      = count;

`ifdef STICKY_OVF_EN
  logic sticky_q;

  // Set has priority so an overflow landing alongside a clear is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (push && new_entry.ovf) begin
      sticky_q <= 1'b1;
    end else if (bus.clr_sticky) begin
      sticky_q <= 1'b0;
    end
  end

  assign bus.sticky_ovf = sticky_q;
`else
  logic unused_clr_sticky;

  assign unused_clr_sticky = bus.clr_sticky;
  assign bus.sticky_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: flags, FIFO order, backpressure, reset and sticky overflow.
module tb_alu_result_stage;
  localparam int WIDTH = 4;

`ifdef STICKY_OVF_EN
  localparam logic STK_EN = 1'b1;
`else
  localparam logic STK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  alu_result_stage_if #(.WIDTH(WIDTH)) bus ();

  alu_result_stage #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic op, input logic [WIDTH-1:0] r1,
                       input logic [WIDTH-1:0] r2, input logic [WIDTH-1:0] res);
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_r1     = r1;
    bus.in_r2     = r2;
    bus.in_result = res;
  endtask

  initial begin
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    bus.out_ready  = 1'b0;
    bus.clr_sticky = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("rst_count", bus.count, 2'd0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_result", bus.out_result, 4'd0);
    check("rst_sticky", bus.sticky_ovf, 1'b0);

    // 7 + 1 = 8: signed overflow, no carry
    drive(1'b1, 1'b0, 4'd7, 4'd1, 4'd8);
    tick();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    check("add_valid", bus.out_valid, 1'b1);
    check("add_result", bus.out_result, 4'd8);
    check("add_zero", bus.out_zero, 1'b0);
    check("add_neg", bus.out_neg, 1'b1);
    check("add_carry", bus.out_carry, 1'b0);
    check("add_ovf", bus.out_ovf, 1'b1);
    check("add_count", bus.count, 2'd1);

    // 3 - 3 = 0, pushed while popping the previous head
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b1, 4'd3, 4'd3, 4'd0);
    tick();
    check("sub0_count", bus.count, 2'd1);
    check("sub0_result", bus.out_result, 4'd0);
    check("sub0_zero", bus.out_zero, 1'b1);
    check("sub0_neg", bus.out_neg, 1'b0);
    check("sub0_carry", bus.out_carry, 1'b1);
    check("sub0_ovf", bus.out_ovf, 1'b0);

    // 2 - 5 = 13: borrow, negative, no overflow; again push+pop at count 1
    drive(1'b1, 1'b1, 4'd2, 4'd5, 4'd13);
    tick();
    check("sub13_count", bus.count, 2'd1);
    check("sub13_result", bus.out_result, 4'd13);
    check("sub13_zero", bus.out_zero, 1'b0);
    check("sub13_neg", bus.out_neg, 1'b1);
    check("sub13_carry", bus.out_carry, 1'b0);
    check("sub13_ovf", bus.out_ovf, 1'b0);

    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    tick();
    check("drain_valid", bus.out_valid, 1'b0);
    tick();
    check("empty_pop_count", bus.count, 2'd0);

    // Backpressure: 1, 2, 3 back to back with out_ready low
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 4'd0, 4'd1, 4'd1);
    tick();
    drive(1'b1, 1'b0, 4'd1, 4'd1, 4'd2);
    tick();
    check("bp_count2", bus.count, 2'd2);
    check("bp_in_ready0", bus.in_ready, 1'b0);
    check("bp_head1", bus.out_result, 4'd1);
    drive(1'b1, 1'b0, 4'd1, 4'd2, 4'd3);
    tick();
    check("bp_hold_count", bus.count, 2'd2);
    check("bp_hold_head", bus.out_result, 4'd1);
    check("bp_hold_in_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_pop1_head", bus.out_result, 4'd2);
    check("bp_pop1_count", bus.count, 2'd1);
    check("bp_pop1_in_ready", bus.in_ready, 1'b1);
    tick();
    check("bp_pop2_head", bus.out_result, 4'd3);
    check("bp_pop2_count", bus.count, 2'd1);

    // 4 + 4 = 8 overflow pushed together with clr_sticky
    bus.out_ready  = 1'b0;
    bus.clr_sticky = 1'b1;
    drive(1'b1, 1'b0, 4'd4, 4'd4, 4'd8);
    tick();
    bus.clr_sticky = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    check("ovf_full_count", bus.count, 2'd2);
    check("ovf_set_wins", bus.sticky_ovf, STK_EN);
    check("ovf_head_kept", bus.out_result, 4'd3);

    // Reset from full wins over a simultaneous push and pop
    rst           = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b0, 4'd4, 4'd4, 4'd8);
    #1;
    check("rst_active_in_ready", bus.in_ready, 1'b1);
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    check("rst2_count", bus.count, 2'd0);
    check("rst2_out_valid", bus.out_valid, 1'b0);
    check("rst2_in_ready", bus.in_ready, 1'b1);
    check("rst2_result", bus.out_result, 4'd0);
    check("rst2_flags", {bus.out_zero, bus.out_neg, bus.out_carry, bus.out_ovf}, 4'b0000);
    check("rst2_sticky", bus.sticky_ovf, 1'b0);

    // Overflow without clear, then clear alone
    drive(1'b1, 1'b0, 4'd4, 4'd4, 4'd8);
    tick();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    check("ovf2_flag", bus.out_ovf, 1'b1);
    check("ovf2_carry", bus.out_carry, 1'b0);
    check("ovf2_neg", bus.out_neg, 1'b1);
    check("ovf2_sticky", bus.sticky_ovf, STK_EN);
    bus.clr_sticky = 1'b1;
    bus.out_ready  = 1'b1;
    tick();
    bus.clr_sticky = 1'b0;
    check("clr_sticky", bus.sticky_ovf, 1'b0);
    check("final_count", bus.count, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
